axi_lite_master_bridge: RTL and testbench
=========================================

Name: axi_lite_master_bridge

Overview:
Single-outstanding AXI4-Lite initiator. Converts the core's simple load/store request port (LSU/IFU side) into AXI-Lite read or write transactions toward the crossbar and devices (CLINT, UART, SRAM). Returns read data or write completion plus an error flag. Includes an optional watchdog that aborts hung transactions.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width; strobe width is DATA_W/8
TIMEOUT, 255, max cycles waiting in any AXI state before abort; 0 disables the watchdog

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
req_valid  in  1  core request present
req_ready  out  1  bridge can accept request
req_wen  in  1  1=write, 0=read
req_addr  in  ADDR_W  byte address
req_wdata  in  DATA_W  store data
req_wstrb  in  DATA_W/8  byte enables
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  DATA_W  read data; 0 for writes
resp_err  out  1  RRESP/BRESP nonzero or timeout
araddr  out  ADDR_W ; arvalid  out  1 ; arready  in  1
rdata  in  DATA_W ; rresp  in  2 ; rvalid  in  1 ; rready  out  1
awaddr  out  ADDR_W ; awvalid  out  1 ; awready  in  1
wdata  out  DATA_W ; wstrb  out  DATA_W/8 ; wvalid  out  1 ; wready  in  1
bresp  in  2 ; bvalid  in  1 ; bready  out  1

Behaviour:
- Reset values: state IDLE; req_ready=1; resp_valid=0; resp_rdata=0; resp_err=0; all AXI valids/readies=0; araddr/awaddr/wdata/wstrb=0; timeout counter=0.
- Reset mid-transaction: all outputs return to reset values at that edge. No response is emitted. The slave is not drained.
- FSM states: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready: latch addr, wdata and wstrb into output registers; req_ready drops next cycle.
  - req_wen=0 -> RD_ADDR with arvalid=1 next cycle.
  - req_wen=1 -> WR_REQ with awvalid=wvalid=1 next cycle.
- RD_ADDR:
  - arvalid held high and araddr stable until arready.
  - On handshake: arvalid=0, rready=1, go to RD_DATA.
- RD_DATA:
  - rready=1.
  - On rvalid: latch rdata into resp_rdata, resp_err=(rresp!=0), resp_valid=1 for one cycle, rready=0, return to IDLE.
  - rvalid is accepted even in the cycle rready first rises.
- WR_REQ:
  - awvalid and wvalid start together. Each drops independently the cycle after its own handshake; handshakes may occur in either order or in the same cycle.
  - Once both are done: bready=1, go to WR_RESP.
- WR_RESP:
  - On bvalid: resp_valid pulse, resp_err=(bresp!=0), resp_rdata=0, bready=0, go to IDLE.
- Latency (zero-wait slave, arready=1, rvalid one cycle after AR handshake):
  - Request accepted edge N.
  - arvalid high N+1; AR handshake N+1.
  - rvalid N+2; resp_valid N+3.
  - Next request accepted at N+3, since req_ready=1 in IDLE.
- resp_valid is never back-pressured; the core must sample it.
- Watchdog (TIMEOUT>0):
  - Counter clears on entering any non-IDLE state and increments each cycle in that state.
  - When it reaches TIMEOUT: deassert all AXI valids/readies, pulse resp_valid with resp_err=1 and resp_rdata=0, go to IDLE.
  - A late slave response after abort is ignored.
- AXI outputs change only on clock edges; no combinational path from the AXI inputs to AXI outputs.
- ARPROT/AWPROT are not driven; the interconnect ties them to 0.

Test Plan:
- Read, zero-wait slave: addr 0xa0000048, slave returns rdata=0x0000_1234, rresp=0 -> arvalid at N+1, resp_valid at N+3, resp_rdata=0x1234, resp_err=0.
- Read with stalls: arready low for 3 cycles, rvalid delayed 4 cycles -> araddr stable throughout; exactly one resp_valid; rready high only in RD_DATA.
- Write, AW accepted before W (wready 2 cycles late), wdata=0xdeadbeef, wstrb=0xf -> awvalid drops after its handshake while wvalid stays high; after bresp=0: resp_valid=1, resp_err=0, resp_rdata=0.
- Write, W before AW, then bresp=2'b10 -> single completion pulse with resp_err=1.
- Timeout, TIMEOUT=8: arready held 0 -> abort on the 8th cycle in RD_ADDR; resp_valid=1, resp_err=1, arvalid=0; a late rvalid produces no second response.
- Reset asserted during RD_DATA -> next cycle: rready=0, req_ready=1, resp_valid=0; a new read then completes normally.

Source files
------------

// File: rtl/axi_lite_master_bridge_if.sv
// Bus bundle for the AXI4-Lite master bridge: the core-side load/store
// request/response port plus the five AXI4-Lite channels.
// The master modport is the bridge's view; the slave modport is the view of
// whatever sits on the other side (core and interconnect together).
interface axi_lite_master_bridge_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int STRB_W = DATA_W / 8;

    // Core request / response
    logic              req_valid;
    logic              req_ready;
    logic              req_wen;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [STRB_W-1:0] req_wstrb;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;

    // Read address / read data channels
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    // Write address / write data / write response channels
    logic [ADDR_W-1:0] awaddr;
    logic              awvalid;
    logic              awready;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;

    modport master (
        input  req_valid, req_wen, req_addr, req_wdata, req_wstrb,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output araddr, arvalid,
        input  arready,
        input  rdata, rresp, rvalid,
        output rready,
        output awaddr, awvalid,
        input  awready,
        output wdata, wstrb, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready
    );

    modport slave (
        output req_valid, req_wen, req_addr, req_wdata, req_wstrb,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  araddr, arvalid,
        output arready,
        output rdata, rresp, rvalid,
        input  rready,
        input  awaddr, awvalid,
        output awready,
        input  wdata, wstrb, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/axi_lite_master_bridge.sv
// Single-outstanding AXI4-Lite initiator. Turns one core load/store request
// into an AXI-Lite read or write, returns a one-cycle completion pulse with
// read data and an error flag, and aborts transactions that hang longer than
// TIMEOUT cycles in any AXI state (TIMEOUT = 0 disables the watchdog).
// Every output is a register, so nothing on the AXI inputs reaches an AXI
// output combinationally.
module axi_lite_master_bridge #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input logic                      clk,
    input logic                      rst,
    axi_lite_master_bridge_if.master bus
);
    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    // The counter starts at 0 on state entry, so the last allowed cycle
    // in a state is the one where it reads TIMEOUT-1.
    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR_REQ,
        WR_RESP
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  wd_cnt;

    logic              req_ready_r;
    logic              resp_valid_r;
    logic [DATA_W-1:0] resp_rdata_r;
    logic              resp_err_r;
    logic [ADDR_W-1:0] araddr_r;
    logic              arvalid_r;
    logic              rready_r;
    logic [ADDR_W-1:0] awaddr_r;
    logic              awvalid_r;
    logic [DATA_W-1:0] wdata_r;
    logic [STRB_W-1:0] wstrb_r;
    logic              wvalid_r;
    logic              bready_r;

    // A write channel counts as done once its valid has been accepted,
    // either on an earlier edge (valid already low) or on this one.
    logic aw_done;
    logic w_done;
    logic progress;
    logic wd_expire;
    logic wd_abort;

    assign aw_done   = !awvalid_r || bus.awready;
    assign w_done    = !wvalid_r  || bus.wready;
    assign wd_expire = (TIMEOUT != 0) && (wd_cnt == WD_LAST);
    // A handshake that completes the current state wins over the watchdog.
    assign wd_abort  = (state != IDLE) && !progress && wd_expire;

    // Does the current AXI state finish on this edge?
    always_comb begin
        progress = 1'b0;
        unique case (state)
            RD_ADDR: progress = bus.arready;
            RD_DATA: progress = bus.rvalid;
            WR_REQ:  progress = aw_done && w_done;
            WR_RESP: progress = bus.bvalid;
            default: progress = 1'b0;
        endcase
    end

    // Transaction FSM with registered outputs and watchdog counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            wd_cnt       <= '0;
            req_ready_r  <= 1'b1;
            resp_valid_r <= 1'b0;
            resp_rdata_r <= '0;
            resp_err_r   <= 1'b0;
            araddr_r     <= '0;
            arvalid_r    <= 1'b0;
            rready_r     <= 1'b0;
            awaddr_r     <= '0;
            awvalid_r    <= 1'b0;
            wdata_r      <= '0;
            wstrb_r      <= '0;
            wvalid_r     <= 1'b0;
            bready_r     <= 1'b0;
        end else begin
            resp_valid_r <= 1'b0;
            wd_cnt       <= wd_cnt + 1'b1;
            if (wd_abort) begin
                arvalid_r    <= 1'b0;
                rready_r     <= 1'b0;
                awvalid_r    <= 1'b0;
                wvalid_r     <= 1'b0;
                bready_r     <= 1'b0;
                resp_valid_r <= 1'b1;
                resp_err_r   <= 1'b1;
                resp_rdata_r <= '0;
                req_ready_r  <= 1'b1;
                wd_cnt       <= '0;
                state        <= IDLE;
            end else begin
                unique case (state)
                    IDLE: begin
                        wd_cnt <= '0;
                        if (bus.req_valid && req_ready_r) begin
                            req_ready_r <= 1'b0;
                            if (bus.req_wen) begin
                                awaddr_r  <= bus.req_addr;
                                wdata_r   <= bus.req_wdata;
                                wstrb_r   <= bus.req_wstrb;
                                awvalid_r <= 1'b1;
                                wvalid_r  <= 1'b1;
                                state     <= WR_REQ;
                            end else begin
                                araddr_r  <= bus.req_addr;
                                arvalid_r <= 1'b1;
                                state     <= RD_ADDR;
                            end
                        end
                    end
                    RD_ADDR: begin
                        if (bus.arready) begin
                            arvalid_r <= 1'b0;
                            rready_r  <= 1'b1;
                            wd_cnt    <= '0;
                            state     <= RD_DATA;
                        end
                    end
                    RD_DATA: begin
                        if (bus.rvalid) begin
                            resp_rdata_r <= bus.rdata;
                            resp_err_r   <= (bus.rresp != 2'b00);
                            resp_valid_r <= 1'b1;
                            rready_r     <= 1'b0;
                            req_ready_r  <= 1'b1;
                            state        <= IDLE;
                        end
                    end
                    WR_REQ: begin
                        // AW and W retire independently, in either order.
                        if (awvalid_r && bus.awready) begin
                            awvalid_r <= 1'b0;
                        end
                        if (wvalid_r && bus.wready) begin
                            wvalid_r <= 1'b0;
                        end
                        if (aw_done && w_done) begin
                            bready_r <= 1'b1;
                            wd_cnt   <= '0;
                            state    <= WR_RESP;
                        end
                    end
                    WR_RESP: begin
                        if (bus.bvalid) begin
                            resp_rdata_r <= '0;
                            resp_err_r   <= (bus.bresp != 2'b00);
                            resp_valid_r <= 1'b1;
                            bready_r     <= 1'b0;
                            req_ready_r  <= 1'b1;
                            state        <= IDLE;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.req_ready  = req_ready_r;
    assign bus.resp_valid = resp_valid_r;
    assign bus.resp_rdata = resp_rdata_r;
    assign bus.resp_err   = resp_err_r;
    assign bus.araddr     = araddr_r;
    assign bus.arvalid    = arvalid_r;
    assign bus.rready     = rready_r;
    assign bus.awaddr     = awaddr_r;
    assign bus.awvalid    = awvalid_r;
    assign bus.wdata      = wdata_r;
    assign bus.wstrb      = wstrb_r;
    assign bus.wvalid     = wvalid_r;
    assign bus.bready     = bready_r;
endmodule

// File: tb/tb_axi_lite_master_bridge.sv
// Bench for axi_lite_master_bridge. The bench plays both the core and an
// AXI-Lite slave whose per-channel stall lengths are chosen per transaction.
// Expected completion cycle, data and error flag come from the protocol's
// timing rules applied to those stall lengths.
module tb_axi_lite_master_bridge;
    localparam int TMO = 8;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    axi_lite_master_bridge_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    axi_lite_master_bridge #(
        .ADDR_W (32),
        .DATA_W (32),
        .TIMEOUT(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One read. Sample k is taken just after the k-th edge counting the
    // acceptance edge as edge 1.
    task automatic do_read(input logic [31:0] addr, input int ar_dly, input int r_dly,
                           input logic [31:0] rd, input logic [1:0] rr, input string tag);
        int          exp_k, got_k, resp_cnt, ar_wait, r_wait, addr_bad, proto_bad, span;
        logic [31:0] exp_d, got_d;
        logic        exp_e, got_e;
        bit          ar_done, r_done;
        if (ar_dly >= TMO) begin
            exp_k = TMO + 1; exp_d = '0; exp_e = 1'b1;
        end else if (r_dly >= TMO) begin
            exp_k = 2 + ar_dly + TMO; exp_d = '0; exp_e = 1'b1;
        end else begin
            exp_k = 3 + ar_dly + r_dly; exp_d = rd; exp_e = (rr != 2'b00);
        end
        got_k = 0; resp_cnt = 0; ar_wait = 0; r_wait = 0; addr_bad = 0; proto_bad = 0;
        got_d = '0; got_e = 1'b0; ar_done = 0; r_done = 0;
        chk({tag, "/req_ready_idle"}, bus.req_ready, 1);
        bus.req_valid = 1'b1;
        bus.req_wen   = 1'b0;
        bus.req_addr  = addr;
        bus.req_wdata = $urandom;
        bus.req_wstrb = 4'($urandom);
        tick();
        bus.req_valid = 1'b0;
        chk({tag, "/req_ready_busy"}, bus.req_ready, 0);
        span = exp_k + 4;
        for (int k = 1; k <= span; k++) begin
            if (k > 1) tick();
            if (bus.resp_valid) begin
                resp_cnt++;
                if (resp_cnt == 1) begin
                    got_k = k; got_d = bus.resp_rdata; got_e = bus.resp_err;
                end
            end
            if (bus.arvalid && bus.araddr !== addr) addr_bad++;
            if (bus.arvalid !== (!ar_done && resp_cnt == 0)) proto_bad++;
            if (bus.rready !== (ar_done && !r_done && resp_cnt == 0)) proto_bad++;
            if (bus.awvalid || bus.wvalid || bus.bready) proto_bad++;
            if (ar_done && !r_done) begin
                bus.rvalid = (r_wait >= r_dly);
                r_wait++;
                if (bus.rvalid) begin
                    r_done = 1; bus.rdata = rd; bus.rresp = rr;
                end
            end else begin
                bus.rvalid = 1'b0; bus.rdata = $urandom; bus.rresp = 2'($urandom);
            end
            if (!ar_done && bus.arvalid) begin
                bus.arready = (ar_wait >= ar_dly);
                ar_wait++;
                if (bus.arready) ar_done = 1;
            end else begin
                bus.arready = 1'b0;
            end
        end
        bus.rvalid  = 1'b0;
        bus.arready = 1'b0;
        chk({tag, "/resp_count"}, resp_cnt, 1);
        chk({tag, "/latency"}, got_k, exp_k);
        chk({tag, "/rdata"}, got_d, exp_d);
        chk({tag, "/err"}, got_e, exp_e);
        chk({tag, "/araddr_stable"}, addr_bad, 0);
        chk({tag, "/handshake_shape"}, proto_bad, 0);
    endtask

    // One write, same sampling scheme as do_read.
    task automatic do_write(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] ws,
                            input int aw_dly, input int w_dly, input int b_dly,
                            input logic [1:0] br, input string tag);
        int   exp_k, got_k, resp_cnt, aw_wait, w_wait, b_wait, data_bad, proto_bad, span, mx;
        logic [31:0] got_d;
        logic exp_e, got_e;
        bit   aw_done, w_done, b_done;
        mx = (aw_dly > w_dly) ? aw_dly : w_dly;
        if (b_dly >= TMO) begin
            exp_k = 2 + mx + TMO; exp_e = 1'b1;
        end else begin
            exp_k = 3 + mx + b_dly; exp_e = (br != 2'b00);
        end
        got_k = 0; resp_cnt = 0; aw_wait = 0; w_wait = 0; b_wait = 0; data_bad = 0; proto_bad = 0;
        got_d = 32'hffff_ffff; got_e = 1'b0; aw_done = 0; w_done = 0; b_done = 0;
        chk({tag, "/req_ready_idle"}, bus.req_ready, 1);
        bus.req_valid = 1'b1;
        bus.req_wen   = 1'b1;
        bus.req_addr  = addr;
        bus.req_wdata = wd;
        bus.req_wstrb = ws;
        tick();
        bus.req_valid = 1'b0;
        bus.req_wdata = ~wd;
        chk({tag, "/req_ready_busy"}, bus.req_ready, 0);
        span = exp_k + 6;
        for (int k = 1; k <= span; k++) begin
            if (k > 1) tick();
            if (bus.resp_valid) begin
                resp_cnt++;
                if (resp_cnt == 1) begin
                    got_k = k; got_d = bus.resp_rdata; got_e = bus.resp_err;
                end
            end
            if (bus.awvalid && bus.awaddr !== addr) data_bad++;
            if (bus.wvalid && (bus.wdata !== wd || bus.wstrb !== ws)) data_bad++;
            if (bus.awvalid !== (!aw_done && resp_cnt == 0)) proto_bad++;
            if (bus.wvalid !== (!w_done && resp_cnt == 0)) proto_bad++;
            if (bus.bready !== (aw_done && w_done && !b_done && resp_cnt == 0)) proto_bad++;
            if (bus.arvalid || bus.rready) proto_bad++;
            if (aw_done && w_done && !b_done) begin
                bus.bvalid = (b_wait >= b_dly);
                b_wait++;
                if (bus.bvalid) begin
                    b_done = 1; bus.bresp = br;
                end
            end else begin
                bus.bvalid = 1'b0; bus.bresp = 2'($urandom);
            end
            if (!aw_done && bus.awvalid) begin
                bus.awready = (aw_wait >= aw_dly);
                aw_wait++;
                if (bus.awready) aw_done = 1;
            end else begin
                bus.awready = 1'b0;
            end
            if (!w_done && bus.wvalid) begin
                bus.wready = (w_wait >= w_dly);
                w_wait++;
                if (bus.wready) w_done = 1;
            end else begin
                bus.wready = 1'b0;
            end
        end
        bus.bvalid  = 1'b0;
        bus.awready = 1'b0;
        bus.wready  = 1'b0;
        chk({tag, "/resp_count"}, resp_cnt, 1);
        chk({tag, "/latency"}, got_k, exp_k);
        chk({tag, "/rdata_zero"}, got_d, 0);
        chk({tag, "/err"}, got_e, exp_e);
        chk({tag, "/aw_w_payload"}, data_bad, 0);
        chk({tag, "/handshake_shape"}, proto_bad, 0);
    endtask

    initial begin
        int b_dly;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.req_valid = 1'b0; bus.req_wen = 1'b0; bus.req_addr = '0;
        bus.req_wdata = '0; bus.req_wstrb = '0;
        bus.arready = 1'b0; bus.rdata = '0; bus.rresp = '0; bus.rvalid = 1'b0;
        bus.awready = 1'b0; bus.wready = 1'b0; bus.bresp = '0; bus.bvalid = 1'b0;
        tick();
        tick();
        chk("reset/req_ready", bus.req_ready, 1);
        chk("reset/resp_valid", bus.resp_valid, 0);
        chk("reset/resp_rdata", bus.resp_rdata, 0);
        chk("reset/resp_err", bus.resp_err, 0);
        chk("reset/valids_readies",
            {bus.arvalid, bus.rready, bus.awvalid, bus.wvalid, bus.bready}, 0);
        chk("reset/araddr", bus.araddr, 0);
        chk("reset/awaddr", bus.awaddr, 0);
        chk("reset/wdata", bus.wdata, 0);
        chk("reset/wstrb", bus.wstrb, 0);
        rst = 1'b0;
        tick();

        do_read(32'ha000_0048, 0, 0, 32'h0000_1234, 2'b00, "rd_zero_wait");
        do_read(32'h8000_0100, 3, 4, 32'hcafe_f00d, 2'b00, "rd_stalled");
        do_write(32'h1000_0000, 32'hdead_beef, 4'hf, 0, 2, 0, 2'b00, "wr_aw_first");
        do_write(32'h1000_0004, 32'h0102_0304, 4'h3, 2, 0, 1, 2'b10, "wr_w_first_slverr");

        // Reset while the read sits in RD_DATA waiting for rvalid.
        bus.req_valid = 1'b1; bus.req_wen = 1'b0; bus.req_addr = 32'h8000_0010;
        tick();
        bus.req_valid = 1'b0;
        bus.arready   = 1'b1;
        tick();
        bus.arready = 1'b0;
        chk("rst_mid/rready_before", bus.rready, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid/rready", bus.rready, 0);
        chk("rst_mid/req_ready", bus.req_ready, 1);
        chk("rst_mid/resp_valid", bus.resp_valid, 0);
        chk("rst_mid/resp_err", bus.resp_err, 0);
        chk("rst_mid/arvalid", bus.arvalid, 0);
        do_read(32'h8000_0020, 1, 1, 32'h5a5a_0001, 2'b00, "rd_after_rst");

        // Slave never accepts AR: watchdog abort, then a stray late rvalid.
        do_read(32'h0200_bff8, 30, 0, 32'h1111_2222, 2'b00, "rd_timeout");
        chk("rd_timeout/arvalid_after", bus.arvalid, 0);
        bus.rvalid = 1'b1; bus.rdata = 32'h7777_7777; bus.rresp = 2'b00;
        tick();
        bus.rvalid = 1'b0;
        chk("late_r/resp_valid_0", bus.resp_valid, 0);
        tick();
        chk("late_r/resp_valid_1", bus.resp_valid, 0);
        chk("late_r/req_ready", bus.req_ready, 1);

        for (int t = 0; t < 30; t++) begin
            if ($urandom_range(1, 0) == 0) begin
                do_read($urandom, $urandom_range(4, 0), $urandom_range(4, 0),
                        $urandom, 2'($urandom_range(3, 0)), "rnd_rd");
            end else begin
                b_dly = ($urandom_range(4, 0) == 0) ? $urandom_range(11, 9) : $urandom_range(4, 0);
                do_write($urandom, $urandom, 4'($urandom), $urandom_range(4, 0),
                         $urandom_range(4, 0), b_dly, 2'($urandom_range(3, 0)), "rnd_wr");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
